// File: rtl/gf8_reduce_seq.sv
// gf8_reduce_seq: sequential GF(2^8) reducer of a 15-bit carry-less product modulo POLY, one bit per cycle.
// Optional GF_REDUCE_ERR_EN adds an err output flagging nonzero product bits 16:15.
module gf8_reduce_seq #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_res,
  output logic        busy
`ifdef GF_REDUCE_ERR_EN
  ,
  output logic        err
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [14:0] acc, poly_sh, acc_step;
  logic [2:0]  cnt;
  logic        hit, accept, release_out;
  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = in_valid && in_ready;
  assign release_out = (state == DONE) && out_ready;
  assign poly_sh     = 15'(POLY) << cnt;
  assign hit         = acc[4'd8 + 4'(cnt)];
  assign acc_step    = hit ? acc ^ poly_sh : acc;
  always_comb begin
    state_n = state;
    state_n = accept ? RUN : (state == RUN && cnt == 3'd0) ? DONE : release_out ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_res   <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      acc <= in_prod[14:0];
      cnt <= 3'd6;
    end else if (state == RUN) begin
      acc <= acc_step;
      if (cnt == 3'd0) begin
        out_res   <= acc_step[7:0];
        out_valid <= 1'b1;
      end else cnt <= cnt - 3'd1;
    end else if (release_out) out_valid <= 1'b0;
`ifdef GF_REDUCE_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (accept) err_q <= |in_prod[16:15];
    else if (release_out) err_q <= 1'b0;
  assign err = err_q & out_valid;
`else
  logic unused_hi;
  assign unused_hi = ^in_prod[16:15];
`endif
endmodule
